// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with B-writer scoreboard
module regfile_wb_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  output logic          a_stall,
  input  logic          b_valid,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  output logic          iss_ready,
  input  logic [AW-1:0] chk_ra1,
  input  logic [AW-1:0] chk_ra2,
  output logic          busy1,
  output logic          busy2,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd
);

  localparam int NR = 1 << AW;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic [NR-1:0] pending, pending_nx;
  logic          a_eff;
  logic          b_hs;
  logic          win;
  logic [AW-1:0] win_wa;
  logic [DW-1:0] win_wd;

  // A has fixed priority unless the starvation guard is stalling it this cycle
  assign a_eff   = a_we & ~a_stall;
  assign b_ready = ~a_eff;
  assign b_hs    = b_valid & b_ready;
  assign win     = a_eff | b_hs;
  assign win_wa  = a_eff ? a_wa : b_wa;
  assign win_wd  = a_eff ? a_wd : b_wd;

  // A same-cycle B commit to the issued register frees it for reissue (WAW check)
  assign iss_ready = ~pending[iss_rd] | (b_hs & (b_wa == iss_rd));
  // Busy is the registered scoreboard only; commit forwarding lives elsewhere
  assign busy1 = pending[chk_ra1];
  assign busy2 = pending[chk_ra2];

  // Starvation FSM: count consecutive B losses, then force one A stall
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      IDLE: begin
        if (b_valid && a_eff) begin
          state_nx    = WAIT;
          wait_cnt_nx = CW'(1);
        end
      end
      WAIT: begin
        if (!b_valid || b_hs) begin
          state_nx    = IDLE;
          wait_cnt_nx = '0;
        end else if (wait_cnt == CW'(MAX_WAIT)) begin
          state_nx    = FORCE;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      FORCE: begin
        state_nx    = IDLE;
        wait_cnt_nx = '0;
      end
      default: begin
        state_nx    = IDLE;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // Scoreboard next value: clear on B commit, then set on issue so set wins
  always_comb begin
    pending_nx = pending;
    if (b_hs) begin
      pending_nx[b_wa] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      pending_nx[iss_rd] = 1'b1;
    end
    pending_nx[0] = 1'b0;
  end

  // FSM, stall and scoreboard registers; a_stall is high exactly while in FORCE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      a_stall  <= 1'b0;
      pending  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      a_stall  <= (state_nx == FORCE);
      pending  <= pending_nx;
    end
  end

  // Register-file write port: one-cycle pulse, writes to x0 are swallowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= win && (win_wa != '0);
      if (win && (win_wa != '0)) begin
        rf_wa <= win_wa;
        rf_wd <= win_wd;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        a_stall;
  logic        b_valid;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_ra1;
  logic [4:0]  chk_ra2;
  logic        busy1;
  logic        busy2;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_checks;
  int n_fail;

  regfile_wb_arbiter #(.AW(5), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd), .a_stall(a_stall),
    .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        b_valid;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        x_b_ready;
    logic        x_iss_ready;
    logic        x_busy1;
    logic        x_busy2;
    logic        x_a_stall;
    logic        x_rf_we;
    logic [4:0]  x_rf_wa;
    logic [31:0] x_rf_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int awe, input int awa, input logic [31:0] awd,
                     input int bv, input int bwa, input logic [31:0] bwd,
                     input int iv, input int ird, input int r1, input int r2,
                     input int xbr, input int xir, input int xb1, input int xb2,
                     input int xst, input int xwe, input int xwa, input logic [31:0] xwd);
    vec_t v;
    v.a_we = 1'(awe);  v.a_wa = 5'(awa);  v.a_wd = awd;
    v.b_valid = 1'(bv); v.b_wa = 5'(bwa); v.b_wd = bwd;
    v.iss_valid = 1'(iv); v.iss_rd = 5'(ird);
    v.ra1 = 5'(r1); v.ra2 = 5'(r2);
    v.x_b_ready = 1'(xbr); v.x_iss_ready = 1'(xir);
    v.x_busy1 = 1'(xb1); v.x_busy2 = 1'(xb2); v.x_a_stall = 1'(xst);
    v.x_rf_we = 1'(xwe); v.x_rf_wa = 5'(xwa); v.x_rf_wd = xwd;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    a_we = 0; a_wa = 0; a_wd = 0;
    b_valid = 0; b_wa = 0; b_wd = 0;
    iss_valid = 0; iss_rd = 0; chk_ra1 = 0; chk_ra2 = 0;
  endtask

  // A writes every cycle while B waits; drop_b removes B on the forced cycle
  task automatic run_starve(input bit drop_b, input string tag);
    int idx;
    for (int k = 0; k < 7; k++) begin
      idx = (k == 6) ? 5 : k;
      a_we = 1; a_wa = 5'(10 + idx); a_wd = 32'h100 + 32'(idx);
      b_valid = drop_b ? (k < 5) : (k < 6);
      b_wa = 5'd3; b_wd = 32'hB0B0B0B0;
      chk_ra1 = 5'd3;
      #1;
      chk($sformatf("%s c%0d a_stall", tag, k), a_stall, (k == 5));
      chk($sformatf("%s c%0d b_ready", tag, k), b_ready, (k == 5));
      tick();
      if (k == 5 && drop_b) begin
        chk($sformatf("%s c%0d rf_we", tag, k), rf_we, 0);
      end else begin
        chk($sformatf("%s c%0d rf_we", tag, k), rf_we, 1);
        chk($sformatf("%s c%0d rf_wa", tag, k), rf_wa, (k == 5) ? 32'd3 : 32'(10 + idx));
        chk($sformatf("%s c%0d rf_wd", tag, k), rf_wd, (k == 5) ? 32'hB0B0B0B0 : 32'h100 + 32'(idx));
      end
    end
    idle_inputs();
    chk_ra1 = 5'd3;
    #1;
    chk({tag, " busy1 r3 after"}, busy1, 0);
    chk({tag, " a_stall after"}, a_stall, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1;
    idle_inputs();

    //  a_we awa awd           bv bwa bwd           iv ird r1 r2 | brdy irdy b1 b2 stl we wa wd
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3, 7,   1, 1, 0, 0, 0, 0, 0, 32'h0);
    add(1, 5, 32'hDEADBEEF,  0, 0, 32'h0,         0, 0, 3, 7,   0, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1, 7, 7, 3,   1, 1, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 7, 3,   1, 1, 1, 0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 3, 7,   1, 0, 1, 1, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         1, 7, 32'h12345678,  0, 7, 7, 3,   1, 1, 1, 1, 0, 1, 7, 32'h12345678);
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 3, 7, 3,   1, 0, 0, 1, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         1, 3, 32'hCAFEF00D,  1, 3, 3, 7,   1, 1, 1, 0, 0, 1, 3, 32'hCAFEF00D);
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 3, 3, 0,   1, 0, 1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 32'hFFFFFFFF,  0, 0, 32'h0,         1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 3,   1, 1, 0, 1, 0, 0, 0, 32'h0);
    add(1, 9, 32'h1,         1, 3, 32'h2,         0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 9, 32'h1);
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3, 0,   1, 1, 1, 0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         1, 0, 32'hAA,        0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 32'h0);

    tick();
    tick();
    chk("reset a_stall", a_stall, 0);
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_wa", rf_wa, 0);
    chk("reset rf_wd", rf_wd, 0);
    rst = 0;
    tick();

    foreach (vecs[i]) begin
      a_we = vecs[i].a_we; a_wa = vecs[i].a_wa; a_wd = vecs[i].a_wd;
      b_valid = vecs[i].b_valid; b_wa = vecs[i].b_wa; b_wd = vecs[i].b_wd;
      iss_valid = vecs[i].iss_valid; iss_rd = vecs[i].iss_rd;
      chk_ra1 = vecs[i].ra1; chk_ra2 = vecs[i].ra2;
      #1;
      chk($sformatf("v%0d b_ready", i), b_ready, vecs[i].x_b_ready);
      chk($sformatf("v%0d iss_ready", i), iss_ready, vecs[i].x_iss_ready);
      chk($sformatf("v%0d busy1", i), busy1, vecs[i].x_busy1);
      chk($sformatf("v%0d busy2", i), busy2, vecs[i].x_busy2);
      chk($sformatf("v%0d a_stall", i), a_stall, vecs[i].x_a_stall);
      tick();
      chk($sformatf("v%0d rf_we", i), rf_we, vecs[i].x_rf_we);
      if (vecs[i].x_rf_we) begin
        chk($sformatf("v%0d rf_wa", i), rf_wa, vecs[i].x_rf_wa);
        chk($sformatf("v%0d rf_wd", i), rf_wd, vecs[i].x_rf_wd);
      end
    end
    idle_inputs();
    tick();

    run_starve(1'b0, "starve");
    run_starve(1'b1, "starve_drop");

    // Reset while in FORCE with registers 4 and 6 pending
    iss_valid = 1; iss_rd = 5'd4;
    tick();
    iss_rd = 5'd6;
    tick();
    iss_valid = 0; iss_rd = 0;
    for (int k = 0; k < 6; k++) begin
      a_we = 1; a_wa = 5'(20 + k); a_wd = 32'h200 + 32'(k);
      b_valid = 1; b_wa = 5'd12; b_wd = 32'h55;
      chk_ra1 = 5'd4; chk_ra2 = 5'd6;
      if (k < 5) tick();
    end
    #1;
    chk("force a_stall", a_stall, 1);
    chk("force busy1 r4", busy1, 1);
    chk("force busy2 r6", busy2, 1);
    chk("force rf_we", rf_we, 1);
    #2;
    rst = 1;
    #1;
    chk("rst a_stall", a_stall, 0);
    chk("rst rf_we", rf_we, 0);
    chk("rst rf_wa", rf_wa, 0);
    chk("rst rf_wd", rf_wd, 0);
    chk("rst busy1 r4", busy1, 0);
    chk("rst busy2 r6", busy2, 0);
    tick();
    rst = 0;
    a_we = 1; a_wa = 5'd21; a_wd = 32'h77; b_valid = 1;
    #1;
    chk("post-rst b_ready", b_ready, 0);
    tick();
    chk("post-rst a_stall", a_stall, 0);
    chk("post-rst rf_wa", rf_wa, 21);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
